// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encodings and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_AW          = 32;
  localparam int DEF_DW          = 32;
  localparam int DEF_MAX_DSTREAK = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_IBUSY = 2'd1;
  localparam arb_state_t ARB_DBUSY = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_streak_cnt.sv
// Saturating count of consecutive data grants taken while a fetch waits;
// sat tells the arbiter the fetch must win the next grant.
module arb_streak_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = DEF_MAX_DSTREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_r;

  // streak counter: clear wins over increment, holds at MAX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between the fetch and data
// ports of the pipeline; data has priority, bounded by a fairness streak limit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_r;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  logic idle_s, sat_s, grant_d_s, grant_i_s, inc_s, clr_s;
  logic i_cpl_s, d_cpl_s;

  // arbitration happens only in IDLE; the bubble between accesses is intentional
  assign idle_s    = (state_r == ARB_IDLE);
  assign grant_d_s = idle_s & d_req & ~(sat_s & if_req);
  assign grant_i_s = idle_s & if_req & ~grant_d_s;
  assign inc_s     = grant_d_s & if_req;
  assign clr_s     = grant_i_s | (idle_s & ~if_req);

  arb_streak_cnt #(.MAX(MAX_DSTREAK)) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (inc_s),
    .clr (clr_s),
    .sat (sat_s)
  );

  // FSM plus latched memory-side command, held stable while BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ARB_IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (grant_d_s) begin
            state_r     <= ARB_DBUSY;
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
          end else if (grant_i_s) begin
            state_r     <= ARB_IBUSY;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= {DW{1'b0}};
          end else begin
            state_r   <= ARB_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          if (mem_ready) begin
            state_r   <= ARB_IDLE;
            mem_req_r <= 1'b0;
          end else begin
            state_r   <= state_r;
            mem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // a port whose requester has gone away gets no data back
  assign i_cpl_s = (state_r == ARB_IBUSY) & mem_ready;
  assign d_cpl_s = (state_r == ARB_DBUSY) & mem_ready;

  // read-data gating and stall generation
  always_comb begin
    if_rdata = {DW{1'b0}};
    d_rdata  = {DW{1'b0}};
    if (i_cpl_s && if_req) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = {DW{1'b0}};
    end
    if (d_cpl_s && d_req) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = {DW{1'b0}};
    end
  end

  assign if_stall  = if_req & ~i_cpl_s;
  assign d_stall   = d_req & ~d_cpl_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, priority,
// wait states, fairness streak and dropped-request behaviour.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  int vectors    = 0;
  int miscompares = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_req_we: got %b%b expected 00", mem_req, mem_we); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_addr_wdata: got %h %h expected 0 0", mem_addr, mem_wdata); end
    vectors++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata, d_rdata); end
    d_req = 1'b1; #1;
    vectors++; if (d_stall !== 1'b1 || if_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_eq: got d=%b i=%b expected d=1 i=0", d_stall, if_stall); end
    d_req = 1'b0; rst = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL reset_busy_req: got %b expected 1", mem_req); end
    rst = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_async_drop: got %b expected 0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_async_addr: got %h expected 0", mem_addr); end
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || d_stall !== 1'b0) begin miscompares++; $display("FAIL reset_release_idle: got req=%b addr=%h dst=%b expected 0 0 0", mem_req, mem_addr, d_stall); end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100; #1;
    vectors++; if (if_stall !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_c0: got stall=%b req=%b expected 1 0", if_stall, mem_req); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hE3A00001; #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_cmd: got req=%b addr=%h we=%b expected 1 100 0", mem_req, mem_addr, mem_we); end
    vectors++; if (if_rdata !== 32'hE3A00001 || if_stall !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_data: got %h stall=%b expected e3a00001 0", if_rdata, if_stall); end
    vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("FAIL fetch_d_rdata_gated: got %h expected 0", d_rdata); end
    tick();
    if_req = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0 || if_rdata !== 32'h0) begin miscompares++; $display("FAIL fetch_c2_idle: got req=%b rdata=%h expected 0 0", mem_req, if_rdata); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b1; #1;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL prio_store_first: got we=%b addr=%h wd=%h expected 1 2000 deadbeef", mem_we, mem_addr, mem_wdata); end
    vectors++; if (d_stall !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL prio_stalls: got d=%b i=%b expected 0 1", d_stall, if_stall); end
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL prio_bubble: got req=%b istall=%b expected 0 1", mem_req, if_stall); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hE1A00000; #1;
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104) begin miscompares++; $display("FAIL prio_fetch_second: got req=%b we=%b addr=%h expected 1 0 104", mem_req, mem_we, mem_addr); end
    vectors++; if (if_rdata !== 32'hE1A00000 || if_stall !== 1'b0) begin miscompares++; $display("FAIL prio_fetch_data: got %h stall=%b expected e1a00000 0", if_rdata, if_stall); end
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (d_stall !== 1'b1 || d_rdata !== 32'h0 || mem_addr !== 32'h3000) begin miscompares++; $display("FAIL wait_cycle%0d: got stall=%b rdata=%h addr=%h expected 1 0 3000", c, d_stall, d_rdata, mem_addr); end
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    vectors++; if (d_rdata !== 32'hCAFEF00D || d_stall !== 1'b0) begin miscompares++; $display("FAIL wait_done: got %h stall=%b expected cafef00d 0", d_rdata, d_stall); end
    tick();
    d_req = 1'b1; #1;
    vectors++; if (d_rdata !== 32'h0 || mem_req !== 1'b0 || d_stall !== 1'b1) begin miscompares++; $display("FAIL wait_one_cycle: got rdata=%h req=%b stall=%b expected 0 0 1", d_rdata, mem_req, d_stall); end
    d_req = 1'b0; mem_ready = 1'b0; #1;
    tick();
  endtask

  task automatic test_fairness();
    logic exp_d;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h11;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    for (int g = 0; g < 10; g++) begin
      exp_d = ((g % 5) != 4);
      tick();
      vectors++; if (mem_req !== 1'b1 || mem_we !== exp_d || mem_addr !== (exp_d ? 32'h4000 : 32'h500)) begin miscompares++; $display("FAIL fair_grant%0d: got req=%b we=%b addr=%h expected data=%b", g, mem_req, mem_we, mem_addr, exp_d); end
      vectors++; if (if_stall !== exp_d) begin miscompares++; $display("FAIL fair_istall%0d: got %b expected %b", g, if_stall, exp_d); end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_dropped();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
    tick();
    d_req = 1'b0; #1;
    vectors++; if (mem_req !== 1'b1 || d_stall !== 1'b0) begin miscompares++; $display("FAIL drop_busy: got req=%b stall=%b expected 1 0", mem_req, d_stall); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h12345678; #1;
    vectors++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin miscompares++; $display("FAIL drop_rdata: got d=%h i=%h expected 0 0", d_rdata, if_rdata); end
    tick();
    mem_ready = 1'b0; #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got %b expected 0", mem_req); end
    tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL drop_no_spurious: got %b expected 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_wait_states();
    test_fairness();
    test_dropped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
